// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants for the interrupt controller.
//   - Bus register addresses (CTRL, MASK, PEND, STAT).
//   - Handshake FSM state encoding (IDLE, REQ, SVC).
//   - Upper bound on the number of interrupt sources.
package int_ctrl_pkg;

    localparam int unsigned N_SRC_MAX = 16;

    // Register map on the 4-word peripheral bus
    localparam logic [1:0] AddrCtrl = 2'b00;
    localparam logic [1:0] AddrMask = 2'b01;
    localparam logic [1:0] AddrPend = 2'b10;
    localparam logic [1:0] AddrStat = 2'b11;

    // Handshake FSM states
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StReq  = 2'd1;
    localparam state_t StSvc  = 2'd2;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index priority encoder.
//   req   in   N   request vector, bit 0 = highest priority
//   valid out  1   any request set
//   index out  W   index of the lowest set bit (0 when none)
module int_prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Scan from the top so the lowest set index is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller with mask, global enable and an irq/ack/EOI
// handshake. Source 0 (timer16) has the highest priority.
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_sel/i_we/i_re  bus select, write and read strobes
//   i_addr, i_wdata  register address and write data
//   o_rdata, o_rdy   combinational read data, ready (= i_sel)
//   i_src            per-source interrupt requests (already in i_clk domain)
//   o_irq, o_vector  request to the CPU and the requesting/in-service source
//   i_ack            CPU acknowledge pulse
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned      N_SRC     = 4,
    parameter int unsigned      VEC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter logic [N_SRC-1:0] EDGE_MASK = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sel,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [1:0]       i_addr,
    input  logic [15:0]      i_wdata,
    output logic [15:0]      o_rdata,
    output logic             o_rdy,
    input  logic [N_SRC-1:0] i_src,
    output logic             o_irq,
    output logic [VEC_W-1:0] o_vector,
    input  logic             i_ack
);

    logic             gie_q;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] src_q;
    state_t           state_q, state_d;
    logic [VEC_W-1:0] vector_q, vector_d;

    logic             wr_ctrl, wr_mask, wr_pend, wr_stat;
    logic [N_SRC-1:0] eligible;
    logic             win_valid;
    logic [VEC_W-1:0] win_idx;
    logic             ack_take;
    logic             eoi;
    logic [N_SRC-1:0] edge_set, edge_clr, edge_next;

    // Write data bits above the implemented register widths are ignored.
    logic unused_wdata;
    assign unused_wdata = ^i_wdata;

    // Bus write decode
    always_comb begin
        wr_ctrl = i_sel && i_we && (i_addr == AddrCtrl);
        wr_mask = i_sel && i_we && (i_addr == AddrMask);
        wr_pend = i_sel && i_we && (i_addr == AddrPend);
        wr_stat = i_sel && i_we && (i_addr == AddrStat);
    end

    assign eligible = pend_q & mask_q & {N_SRC{gie_q}};
    assign ack_take = (state_q == StReq) && i_ack;
    assign eoi      = wr_stat && (state_q == StSvc);

    int_prio_enc #(
        .N (N_SRC),
        .W (VEC_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .index (win_idx)
    );

    // Pending next state: level sources track the input, edge sources latch
    // rising edges until W1C or acknowledge; a new edge beats a clear.
    always_comb begin
        edge_set = i_src & ~src_q;
        edge_clr = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            edge_clr[i] = (wr_pend && i_wdata[i]) || (ack_take && (vector_q == VEC_W'(i)));
        end
        edge_next = edge_set | (pend_q & ~edge_clr);
        pend_d    = (EDGE_MASK & edge_next) | (~EDGE_MASK & i_src);
    end

    // Handshake FSM; the vector is frozen once a request is raised.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d  = StReq;
                    vector_d = win_idx;
                end
            end
            StReq: begin
                if (ack_take) begin
                    state_d = StSvc;
                end else if (!eligible[vector_q]) begin
                    state_d = StIdle;
                end
            end
            StSvc: begin
                if (eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gie_q    <= 1'b0;
            mask_q   <= '0;
            pend_q   <= '0;
            src_q    <= '0;
            state_q  <= StIdle;
            vector_q <= '0;
        end else begin
            if (wr_ctrl) begin
                gie_q <= i_wdata[0];
            end
            if (wr_mask) begin
                mask_q <= i_wdata[N_SRC-1:0];
            end
            pend_q   <= pend_d;
            src_q    <= i_src;
            state_q  <= state_d;
            vector_q <= vector_d;
        end
    end

    assign o_irq    = (state_q == StReq);
    assign o_vector = vector_q;
    assign o_rdy    = i_sel;

    // Combinational read mux; unimplemented bits read as zero.
    always_comb begin
        o_rdata = '0;
        if (i_sel && i_re) begin
            case (i_addr)
                AddrCtrl: o_rdata[0] = gie_q;
                AddrMask: o_rdata[N_SRC-1:0] = mask_q;
                AddrPend: o_rdata[N_SRC-1:0] = pend_q;
                AddrStat: begin
                    o_rdata[15]        = (state_q == StSvc);
                    o_rdata[VEC_W-1:0] = vector_q;
                end
                default: o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl (4 sources, source 2
// edge-triggered). Inputs change on the falling edge; outputs are sampled there.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        sel, we, re;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;
    logic [3:0]  src;
    logic        irq;
    logic [1:0]  vector;
    logic        ack;

    int n_checks = 0;
    int n_fail   = 0;

    int_ctrl #(
        .N_SRC     (4),
        .VEC_W     (2),
        .EDGE_MASK (4'b0100)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_sel    (sel),
        .i_we     (we),
        .i_re     (re),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_rdy    (rdy),
        .i_src    (src),
        .o_irq    (irq),
        .o_vector (vector),
        .i_ack    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        sel = 1'b1; re = 1'b1; addr = a;
        #1;
        d = rdata;
        sel = 1'b0; re = 1'b0;
        check_eq(tag, d, exp);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 0; we = 0; re = 0; addr = '0; wdata = '0; src = '0; ack = 0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_irq", 16'(irq), 16'h0);
        check_eq("rst_vec", 16'(vector), 16'h0);
        chk_reg("rst_ctrl", AddrCtrl, 16'h0000);
        chk_reg("rst_mask", AddrMask, 16'h0000);
        chk_reg("rst_pend", AddrPend, 16'h0000);
        chk_reg("rst_stat", AddrStat, 16'h0000);

        // 1: level timer source, full handshake
        bus_write(AddrCtrl, 16'h0001);
        bus_write(AddrMask, 16'h0001);
        src[0] = 1'b1;
        tick(1);
        check_eq("t1_irq_early", 16'(irq), 16'h0);
        tick(1);
        check_eq("t1_irq", 16'(irq), 16'h1);
        check_eq("t1_vec", 16'(vector), 16'h0);
        ack_pulse();
        src[0] = 1'b0;
        check_eq("t1_irq_svc", 16'(irq), 16'h0);
        chk_reg("t1_stat_svc", AddrStat, 16'h8000);
        bus_write(AddrStat, 16'h0000);
        chk_reg("t1_stat_eoi", AddrStat, 16'h0000);
        tick(1);
        check_eq("t1_irq_idle", 16'(irq), 16'h0);

        // 2: priority between src1 and src3
        bus_write(AddrMask, 16'h000F);
        src[1] = 1'b1; src[3] = 1'b1;
        tick(2);
        check_eq("t2_irq", 16'(irq), 16'h1);
        check_eq("t2_vec1", 16'(vector), 16'h1);
        ack_pulse();
        bus_write(AddrStat, 16'h0000);
        tick(1);
        check_eq("t2_irq_again", 16'(irq), 16'h1);
        check_eq("t2_vec1_again", 16'(vector), 16'h1);
        ack_pulse();
        src[1] = 1'b0;
        bus_write(AddrStat, 16'h0000);
        tick(1);
        check_eq("t2_irq_v3", 16'(irq), 16'h1);
        check_eq("t2_vec3", 16'(vector), 16'h3);
        ack_pulse();
        src[3] = 1'b0;
        bus_write(AddrStat, 16'h0000);
        tick(1);
        check_eq("t2_irq_done", 16'(irq), 16'h0);

        // 3: edge source 2
        src[2] = 1'b1;
        tick(1);
        src[2] = 1'b0;
        chk_reg("t3_pend_set", AddrPend, 16'h0004);
        tick(1);
        check_eq("t3_irq", 16'(irq), 16'h1);
        check_eq("t3_vec", 16'(vector), 16'h2);
        tick(2);
        chk_reg("t3_pend_held", AddrPend, 16'h0004);
        ack_pulse();
        chk_reg("t3_pend_ackclr", AddrPend, 16'h0000);
        chk_reg("t3_stat_svc", AddrStat, 16'h8002);
        bus_write(AddrStat, 16'h0000);
        bus_write(AddrCtrl, 16'h0000);
        src[2] = 1'b1;
        tick(1);
        src[2] = 1'b0;
        tick(2);
        chk_reg("t3_pend_gie0", AddrPend, 16'h0004);
        check_eq("t3_irq_gie0", 16'(irq), 16'h0);
        bus_write(AddrPend, 16'h0004);
        chk_reg("t3_pend_w1c", AddrPend, 16'h0000);
        check_eq("t3_irq_w1c", 16'(irq), 16'h0);

        // 4: withdraw in REQ, then ack in the withdraw cycle
        bus_write(AddrCtrl, 16'h0001);
        src[0] = 1'b1;
        tick(2);
        check_eq("t4_irq", 16'(irq), 16'h1);
        src[0] = 1'b0;
        tick(1);
        check_eq("t4_irq_hold", 16'(irq), 16'h1);
        tick(1);
        check_eq("t4_irq_drop", 16'(irq), 16'h0);
        chk_reg("t4_stat_idle", AddrStat, 16'h0000);
        src[0] = 1'b1;
        tick(2);
        check_eq("t4_irq2", 16'(irq), 16'h1);
        src[0] = 1'b0;
        tick(1);
        ack_pulse();
        check_eq("t4_irq_ackwin", 16'(irq), 16'h0);
        chk_reg("t4_stat_ackwin", AddrStat, 16'h8000);
        bus_write(AddrStat, 16'h0000);
        tick(1);
        check_eq("t4_irq_end", 16'(irq), 16'h0);

        // 5: mask and global enable
        bus_write(AddrMask, 16'h0000);
        src[0] = 1'b1;
        tick(3);
        check_eq("t5_irq_masked", 16'(irq), 16'h0);
        chk_reg("t5_pend_masked", AddrPend, 16'h0001);
        bus_write(AddrMask, 16'h0001);
        tick(1);
        check_eq("t5_irq_unmask", 16'(irq), 16'h1);
        bus_write(AddrCtrl, 16'h0000);
        tick(1);
        check_eq("t5_irq_gieoff", 16'(irq), 16'h0);
        src[0] = 1'b0;
        tick(1);

        // 6: reset in SVC with an edge pending
        bus_write(AddrCtrl, 16'h0001);
        bus_write(AddrMask, 16'h000F);
        src[0] = 1'b1;
        tick(2);
        check_eq("t6_irq", 16'(irq), 16'h1);
        ack_pulse();
        chk_reg("t6_stat_svc", AddrStat, 16'h8000);
        src[2] = 1'b1;
        tick(1);
        src[2] = 1'b0;
        chk_reg("t6_pend_pre", AddrPend, 16'h0005);
        rst = 1'b1;
        src[0] = 1'b0;
        tick(1);
        check_eq("t6_irq_rst", 16'(irq), 16'h0);
        check_eq("t6_vec_rst", 16'(vector), 16'h0);
        chk_reg("t6_stat_rst", AddrStat, 16'h0000);
        rst = 1'b0;
        tick(1);
        chk_reg("t6_ctrl", AddrCtrl, 16'h0000);
        chk_reg("t6_mask", AddrMask, 16'h0000);
        chk_reg("t6_pend", AddrPend, 16'h0000);
        bus_write(AddrCtrl, 16'h0001);
        sel = 1'b1; re = 1'b0; addr = AddrCtrl;
        #1;
        check_eq("t6_rdata_nore", rdata, 16'h0000);
        check_eq("t6_rdy_sel", 16'(rdy), 16'h1);
        re = 1'b1;
        #1;
        check_eq("t6_rdata_re", rdata, 16'h0001);
        sel = 1'b0; re = 1'b0;
        #1;
        check_eq("t6_rdy_nosel", 16'(rdy), 16'h0);
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
